// File: rtl/reg_file_pkg.sv
// Shared widths, reset constants and scoreboard helpers for the general-register file.
// The scoreboard step/busy rules live here so every user applies them identically.
package reg_file_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int RegNum = 16;
    localparam int CNT_W  = 2;

    localparam logic RstEnable = 1'b1;
    localparam logic Disable   = 1'b0;

    typedef logic [DATA_W-1:0] reg_bus_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [CNT_W-1:0]  scb_cnt_t;

    localparam reg_bus_t ZeroWord = '0;
    localparam scb_cnt_t CntZero  = '0;
    localparam scb_cnt_t CntOne   = scb_cnt_t'(1);
    localparam scb_cnt_t CntMax   = '1;

    typedef struct packed {
        logic     err;
        scb_cnt_t cnt;
    } scb_step_t;

    // Simultaneous issue and write-back cancel out, even at the counter limits.
    function automatic scb_step_t scb_step(input scb_cnt_t cnt, input logic inc, input logic dec);
        scb_step_t r;
        r.err = 1'b0;
        r.cnt = cnt;
        if (inc && !dec) begin
            if (cnt == CntMax) r.err = 1'b1;
            else               r.cnt = cnt + CntOne;
        end else if (dec && !inc) begin
            if (cnt == CntZero) r.err = 1'b1;
            else                r.cnt = cnt - CntOne;
        end
        return r;
    endfunction

    // A sole producer committing this cycle is served by the bypass, so it does not stall.
    function automatic logic scb_busy(input scb_cnt_t cnt, input logic commit_hit);
        return (cnt != CntZero) && !((cnt == CntOne) && commit_hit);
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register in-flight write counters, decode busy flags and sticky over/underflow flag.
// Counters move at the clock edge; busy flags are combinational from the current counts.
module reg_scoreboard
    import reg_file_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_i,
    input  logic [ADDR_W-1:0] issueAddr_i,
    input  logic              flush_i,
    input  logic              wReg_i,
    input  logic [ADDR_W-1:0] wRegAddr_i,
    input  logic [ADDR_W-1:0] rAddr1_i,
    input  logic [ADDR_W-1:0] rAddr2_i,
    output logic              rBusy1_o,
    output logic              rBusy2_o,
    output logic              err_o
);

    scb_cnt_t  cnt      [RegNum];
    scb_cnt_t  cnt_nxt  [RegNum];
    scb_step_t step_r   [RegNum];
    logic      step_err;
    logic      err_q;

    always_comb begin
        step_err = 1'b0;
        for (int i = 0; i < RegNum; i++) begin
            step_r[i]  = scb_step(cnt[i],
                                  issue_i && (issueAddr_i == reg_addr_t'(i)),
                                  wReg_i  && (wRegAddr_i  == reg_addr_t'(i)));
            cnt_nxt[i] = step_r[i].cnt;
            step_err   = step_err | step_r[i].err;
        end
    end

    // Flush wipes every pending producer but leaves the sticky error untouched.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            for (int i = 0; i < RegNum; i++) cnt[i] <= CntZero;
            err_q <= Disable;
        end else if (flush_i) begin
            for (int i = 0; i < RegNum; i++) cnt[i] <= CntZero;
        end else begin
            for (int i = 0; i < RegNum; i++) cnt[i] <= cnt_nxt[i];
            if (step_err) err_q <= 1'b1;
        end
    end

    assign rBusy1_o = scb_busy(cnt[rAddr1_i], wReg_i && (wRegAddr_i == rAddr1_i));
    assign rBusy2_o = scb_busy(cnt[rAddr2_i], wReg_i && (wRegAddr_i == rAddr2_i));
    assign err_o    = err_q;

endmodule

// File: rtl/reg_file.sv
// General-register file: one write-back port, two combinational read ports with
// same-cycle write bypass, plus the in-flight producer scoreboard for decode stalls.
module reg_file
    import reg_file_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wReg_i,
    input  logic [ADDR_W-1:0] wRegAddr_i,
    input  logic [DATA_W-1:0] wData_i,
    input  logic [ADDR_W-1:0] rAddr1_i,
    input  logic [ADDR_W-1:0] rAddr2_i,
    output logic [DATA_W-1:0] rData1_o,
    output logic [DATA_W-1:0] rData2_o,
    output logic              rBusy1_o,
    output logic              rBusy2_o,
    input  logic              issue_i,
    input  logic [ADDR_W-1:0] issueAddr_i,
    input  logic              flush_i,
    output logic              err_o
);

    reg_bus_t regs [RegNum];

    // Every register is writable; there is no hard-wired zero register.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            for (int i = 0; i < RegNum; i++) regs[i] <= ZeroWord;
        end else if (wReg_i) begin
            regs[wRegAddr_i] <= wData_i;
        end
    end

    // Bypass stays active during reset: the read rule does not depend on rst.
    always_comb begin
        rData1_o = regs[rAddr1_i];
        rData2_o = regs[rAddr2_i];
        if (wReg_i && (wRegAddr_i == rAddr1_i)) rData1_o = wData_i;
        if (wReg_i && (wRegAddr_i == rAddr2_i)) rData2_o = wData_i;
    end

    reg_scoreboard u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .issue_i     (issue_i),
        .issueAddr_i (issueAddr_i),
        .flush_i     (flush_i),
        .wReg_i      (wReg_i),
        .wRegAddr_i  (wRegAddr_i),
        .rAddr1_i    (rAddr1_i),
        .rAddr2_i    (rAddr2_i),
        .rBusy1_o    (rBusy1_o),
        .rBusy2_o    (rBusy2_o),
        .err_o       (err_o)
    );

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: directed scenarios then random traffic, all outputs
// compared every cycle against a plain-array model of the register file rules.
module tb_reg_file;

    logic        clk;
    logic        rst;
    logic        wReg_i;
    logic [3:0]  wRegAddr_i;
    logic [15:0] wData_i;
    logic [3:0]  rAddr1_i;
    logic [3:0]  rAddr2_i;
    logic [15:0] rData1_o;
    logic [15:0] rData2_o;
    logic        rBusy1_o;
    logic        rBusy2_o;
    logic        issue_i;
    logic [3:0]  issueAddr_i;
    logic        flush_i;
    logic        err_o;

    int total = 0;
    int bad   = 0;

    int m_regs [16];
    int m_cnt  [16];
    int m_err;

    reg_file dut (
        .clk         (clk),
        .rst         (rst),
        .wReg_i      (wReg_i),
        .wRegAddr_i  (wRegAddr_i),
        .wData_i     (wData_i),
        .rAddr1_i    (rAddr1_i),
        .rAddr2_i    (rAddr2_i),
        .rData1_o    (rData1_o),
        .rData2_o    (rData2_o),
        .rBusy1_o    (rBusy1_o),
        .rBusy2_o    (rBusy2_o),
        .issue_i     (issue_i),
        .issueAddr_i (issueAddr_i),
        .flush_i     (flush_i),
        .err_o       (err_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "simulation time limit reached");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic r, input logic wr, input logic [3:0] wa, input logic [15:0] wd,
                          input logic [3:0] a1, input logic [3:0] a2,
                          input logic iss, input logic [3:0] ia, input logic fl);
        rst = r; wReg_i = wr; wRegAddr_i = wa; wData_i = wd;
        rAddr1_i = a1; rAddr2_i = a2; issue_i = iss; issueAddr_i = ia; flush_i = fl;
        #1;
    endtask

    function automatic logic [15:0] m_read(input logic [3:0] a);
        if (wReg_i && wRegAddr_i == a) return wData_i;
        return m_regs[a][15:0];
    endfunction

    // A register stalls decode while writes are owed, unless the only one is landing now.
    function automatic logic [15:0] m_busy(input logic [3:0] a);
        int owed;
        owed = m_cnt[a];
        if (wReg_i && wRegAddr_i == a) owed = owed - 1;
        return {15'd0, owed > 0};
    endfunction

    task automatic check_model();
        chk("rdata1", rData1_o, m_read(rAddr1_i));
        chk("rdata2", rData2_o, m_read(rAddr2_i));
        chk("busy1", {15'd0, rBusy1_o}, m_busy(rAddr1_i));
        chk("busy2", {15'd0, rBusy2_o}, m_busy(rAddr2_i));
        chk("err", {15'd0, err_o}, m_err[15:0]);
    endtask

    task automatic drive(input logic r, input logic wr, input logic [3:0] wa, input logic [15:0] wd,
                         input logic [3:0] a1, input logic [3:0] a2,
                         input logic iss, input logic [3:0] ia, input logic fl);
        set_in(r, wr, wa, wd, a1, a2, iss, ia, fl);
        check_model();
    endtask

    task automatic tick();
        int inc, dec;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 16; i++) begin m_regs[i] = 0; m_cnt[i] = 0; end
            m_err = 0;
        end else begin
            if (wReg_i) m_regs[wRegAddr_i] = int'(wData_i);
            if (flush_i) begin
                for (int i = 0; i < 16; i++) m_cnt[i] = 0;
            end else begin
                for (int i = 0; i < 16; i++) begin
                    inc = (issue_i && issueAddr_i == i) ? 1 : 0;
                    dec = (wReg_i && wRegAddr_i == i) ? 1 : 0;
                    if (m_cnt[i] + inc - dec > 3 || m_cnt[i] + inc - dec < 0) m_err = 1;
                    else m_cnt[i] = m_cnt[i] + inc - dec;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin m_regs[i] = 0; m_cnt[i] = 0; end
        m_err = 0;
        @(negedge clk);
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // reset state on all addresses
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 0, 0, 4'(i), 4'(15 - i), 0, 0, 0);
            chk("rst_rdata1", rData1_o, 16'h0000);
            chk("rst_rdata2", rData2_o, 16'h0000);
            chk("rst_busy", {14'd0, rBusy1_o, rBusy2_o}, 16'h0000);
            chk("rst_err", {15'd0, err_o}, 16'h0000);
            tick();
        end

        // bypass then array read
        drive(0, 1, 3, 16'hBEEF, 3, 0, 0, 0, 0);
        chk("bypass_r3", rData1_o, 16'hBEEF);
        tick();
        drive(0, 0, 0, 0, 3, 3, 0, 0, 0);
        chk("array_r3", rData1_o, 16'hBEEF);
        tick();

        // two producers on R5
        drive(0, 0, 0, 0, 0, 5, 1, 5, 0); tick();
        drive(0, 0, 0, 0, 0, 5, 1, 5, 0); tick();
        drive(0, 0, 0, 0, 0, 5, 0, 0, 0);
        chk("r5_busy_cnt2", {15'd0, rBusy2_o}, 16'h0001);
        tick();
        drive(0, 1, 5, 16'h1111, 0, 5, 0, 0, 0);
        chk("r5_busy_wb1", {15'd0, rBusy2_o}, 16'h0001);
        tick();
        drive(0, 1, 5, 16'h2222, 0, 5, 0, 0, 0);
        chk("r5_busy_wb2", {15'd0, rBusy2_o}, 16'h0000);
        chk("r5_bypass", rData2_o, 16'h2222);
        tick();

        // overflow on R7, then underflow on R0 keeps err sticky
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 0, 7, 7, 1, 7, 0); tick();
        end
        drive(0, 0, 0, 0, 7, 7, 0, 0, 0);
        chk("r7_overflow_err", {15'd0, err_o}, 16'h0001);
        chk("r7_busy", {15'd0, rBusy1_o}, 16'h0001);
        tick();
        drive(0, 1, 0, 16'h00AA, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("err_sticky", {15'd0, err_o}, 16'h0001);
        tick();

        // clean slate, then simultaneous issue+wb and flush+wb on R2
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 2, 2, 1, 2, 0); tick();
        drive(0, 1, 2, 16'h0BAD, 2, 2, 1, 2, 0); tick();
        drive(0, 0, 0, 0, 2, 2, 0, 0, 0);
        chk("r2_cnt_hold_busy", {15'd0, rBusy1_o}, 16'h0001);
        chk("r2_no_err", {15'd0, err_o}, 16'h0000);
        tick();
        drive(0, 1, 2, 16'h1234, 0, 0, 1, 2, 1); tick();
        drive(0, 0, 0, 0, 2, 2, 0, 0, 0);
        chk("flush_busy", {15'd0, rBusy1_o}, 16'h0000);
        chk("flush_data", rData1_o, 16'h1234);
        tick();

        // reset mid-stream with a pending R9 issue
        drive(0, 0, 0, 0, 9, 9, 1, 9, 0); tick();
        drive(0, 1, 9, 16'h5555, 9, 9, 1, 9, 0); tick();
        drive(1, 0, 0, 0, 9, 9, 1, 9, 0);
        chk("rst_read_follows_array", rData1_o, 16'h5555);
        tick();
        drive(0, 0, 0, 0, 9, 9, 0, 0, 0);
        chk("r9_after_rst", rData1_o, 16'h0000);
        chk("r9_busy_after_rst", {15'd0, rBusy1_o}, 16'h0000);
        chk("err_after_rst", {15'd0, err_o}, 16'h0000);
        tick();

        // random traffic; narrow address pool on some cycles to force collisions
        for (int n = 0; n < 600; n++) begin
            logic [3:0] hi;
            hi = ($urandom_range(0, 1) == 1) ? 4'd3 : 4'd15;
            drive(($urandom_range(0, 59) == 0),
                  ($urandom_range(0, 2) != 0),
                  4'($urandom_range(0, hi)), 16'($urandom),
                  4'($urandom_range(0, hi)), 4'($urandom_range(0, hi)),
                  ($urandom_range(0, 2) != 0),
                  4'($urandom_range(0, hi)),
                  ($urandom_range(0, 24) == 0));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
